// File: rtl/hand_packet_scheduler_if.sv
// Handshake and data bundle between the hand-coordinate source, the scheduler
// and the byte-wide UART transmitter.
interface hand_packet_scheduler_if;
  logic        enable;
  logic        coord_valid;
  logic [11:0] hand_x_left_top;
  logic [11:0] hand_y_left_top;
  logic [11:0] hand_x_left_bottom;
  logic [11:0] hand_y_left_bottom;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        packet_active;
  logic [15:0] packets_sent;
  logic [7:0]  dropped_updates;

  // Environment side: supplies coordinates and transmitter status
  modport master (
    output enable, coord_valid,
    output hand_x_left_top, hand_y_left_top, hand_x_left_bottom, hand_y_left_bottom,
    output tx_busy,
    input  tx_start, tx_data, packet_active, packets_sent, dropped_updates
  );

  // Scheduler side
  modport slave (
    input  enable, coord_valid,
    input  hand_x_left_top, hand_y_left_top, hand_x_left_bottom, hand_y_left_bottom,
    input  tx_busy,
    output tx_start, tx_data, packet_active, packets_sent, dropped_updates
  );
endinterface

// File: rtl/hand_packet_scheduler.sv
// Frames camera 2's hand coordinates into sync-prefixed packets and feeds them
// byte by byte to a start/busy UART transmitter, with one pending update slot.
module hand_packet_scheduler #(
  parameter int unsigned SYNC_BYTES  = 3,
  parameter logic [7:0]  SYNC_VALUE  = 8'hFF,
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter bit          FREE_RUN    = 1'b0
) (
  input  logic             clk_65mhz,
  input  logic             sys_rst,
  hand_packet_scheduler_if.slave bus
);

  localparam int unsigned NUM_BYTES = SYNC_BYTES + 6;
  localparam int unsigned IDX_W     = $clog2(NUM_BYTES);
  localparam int unsigned TMO_W     = $clog2(ACK_TIMEOUT) + 1;
  localparam int unsigned SNAP_W    = 48;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);
  localparam logic [IDX_W-1:0] SYNC_N   = IDX_W'(SYNC_BYTES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

  // CAPTURE is the staging cycle between a direct snapshot load and its first byte
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CAPTURE   = 3'd1,
    LOAD      = 3'd2,
    WAIT_ACK  = 3'd3,
    WAIT_DONE = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [SNAP_W-1:0]   snap_q, snap_d;
  logic [SNAP_W-1:0]   shadow_q, shadow_d;
  logic                pending_q, pending_d;
  logic                tx_start_q, tx_start_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                active_q, active_d;
  logic [15:0]         sent_q, sent_d;
  logic [7:0]          dropped_q, dropped_d;

  logic [SNAP_W-1:0]   coords_c;
  logic                direct_cap_c;
  logic                take_shadow_c;
  logic                done_last_c;

  // Byte for a given packet index: sync header, then top pair, then bottom pair
  function automatic logic [7:0] pick_byte(input logic [IDX_W-1:0] idx,
                                           input logic [SNAP_W-1:0] s);
    logic [11:0]      tx, ty, bx, by;
    logic [IDX_W-1:0] off;
    logic [7:0]       b;
    {tx, ty, bx, by} = s;
    off = idx - SYNC_N;
    if (idx < SYNC_N) begin
      b = SYNC_VALUE;
    end else begin
      case (off)
        IDX_W'(0): b = tx[11:4];
        IDX_W'(1): b = ty[7:0];
        IDX_W'(2): b = {tx[3:0], ty[11:8]};
        IDX_W'(3): b = bx[11:4];
        IDX_W'(4): b = by[7:0];
        IDX_W'(5): b = {bx[3:0], by[11:8]};
        default:   b = 8'h00;
      endcase
    end
    return b;
  endfunction

  // Next-state, snapshot/shadow bookkeeping and registered output preparation
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    tmo_d         = tmo_q;
    snap_d        = snap_q;
    shadow_d      = shadow_q;
    pending_d     = pending_q;
    tx_start_d    = 1'b0;
    tx_data_d     = tx_data_q;
    active_d      = active_q;
    sent_d        = sent_q;
    dropped_d     = dropped_q;
    take_shadow_c = 1'b0;
    done_last_c   = 1'b0;
    coords_c      = {bus.hand_x_left_top, bus.hand_y_left_top,
                     bus.hand_x_left_bottom, bus.hand_y_left_bottom};
    direct_cap_c  = (state_q == IDLE) && bus.enable && !pending_q && !FREE_RUN &&
                    bus.coord_valid;

    case (state_q)
      IDLE: begin
        if (pending_q && bus.enable) begin
          take_shadow_c = 1'b1;
          state_d       = LOAD;
        end else if (FREE_RUN && bus.enable) begin
          state_d = LOAD;
        end else if (direct_cap_c) begin
          snap_d  = coords_c;
          state_d = CAPTURE;
        end
      end
      CAPTURE: state_d = LOAD;
      LOAD: begin
        // Timer counts elapsed cycles including the pulse cycle itself
        tmo_d   = TMO_W'(1);
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (bus.tx_busy) begin
          state_d = WAIT_DONE;
        end else if (tmo_q >= TMO_LAST) begin
          state_d = LOAD;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          if (idx_q != LAST_IDX) begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = LOAD;
          end else begin
            done_last_c = 1'b1;
            idx_d       = '0;
            sent_d      = sent_q + 16'd1;
            if (pending_q && bus.enable) begin
              take_shadow_c = 1'b1;
              state_d       = LOAD;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (take_shadow_c) begin
      snap_d    = shadow_q;
      pending_d = 1'b0;
    end

    // Updates that cannot start a packet right away park in the shadow slot
    if (bus.coord_valid && !direct_cap_c) begin
      shadow_d  = coords_c;
      pending_d = 1'b1;
      if (pending_q && !take_shadow_c && (dropped_q != 8'hFF)) begin
        dropped_d = dropped_q + 8'd1;
      end
    end

    if (state_d == LOAD) begin
      tx_start_d = 1'b1;
      tx_data_d  = pick_byte(idx_d, snap_d);
      active_d   = 1'b1;
    end else if (done_last_c) begin
      active_d = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk_65mhz or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk_65mhz or posedge sys_rst) begin
    if (sys_rst) begin
      idx_q      <= '0;
      tmo_q      <= '0;
      snap_q     <= '0;
      shadow_q   <= '0;
      pending_q  <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      active_q   <= 1'b0;
      sent_q     <= '0;
      dropped_q  <= '0;
    end else begin
      idx_q      <= idx_d;
      tmo_q      <= tmo_d;
      snap_q     <= snap_d;
      shadow_q   <= shadow_d;
      pending_q  <= pending_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      active_q   <= active_d;
      sent_q     <= sent_d;
      dropped_q  <= dropped_d;
    end
  end

  assign bus.tx_start        = tx_start_q;
  assign bus.tx_data         = tx_data_q;
  assign bus.packet_active   = active_q;
  assign bus.packets_sent    = sent_q;
  assign bus.dropped_updates = dropped_q;

endmodule

// File: doc/hand_packet_scheduler.md
Name: hand_packet_scheduler

Overview:
- Sequences the byte-wide UART transmitter that carries camera 2's hand coordinates to camera 1.
- Snapshots the left-top and left-bottom hand (x,y) pairs on each coordinate update and frames them as a 9-byte packet: sync header plus 6 payload bytes.
- Issues one byte at a time using the transmitter's start/busy handshake.
- Holds at most one pending update while a packet is in flight.

Parameters:
- SYNC_BYTES, 3, number of header bytes sent before the payload
- SYNC_VALUE, 8'hFF, value of each header byte
- ACK_TIMEOUT, 16, cycles to wait for tx_busy to rise after a tx_start pulse before the byte is re-issued
- FREE_RUN, 0, when 1 the block re-sends the current snapshot back-to-back whenever idle and enabled

Ports:
- clk_65mhz  in  1  system clock
- sys_rst  in  1  asynchronous active-high reset
- enable  in  1  permits new packets to start
- coord_valid  in  1  one-cycle pulse: new coordinates are present on the hand_* inputs
- hand_x_left_top  in  12  top hand x
- hand_y_left_top  in  12  top hand y
- hand_x_left_bottom  in  12  bottom hand x
- hand_y_left_bottom  in  12  bottom hand y
- tx_busy  in  1  transmitter busy; high while a byte is shifting out
- tx_start  out  1  one-cycle pulse requesting transmission of tx_data
- tx_data  out  8  byte to send; held stable from the tx_start pulse until the byte completes
- packet_active  out  1  high from the first tx_start of a packet until its last byte completes
- packets_sent  out  16  count of completed packets; wraps at 16'hFFFF to 0
- dropped_updates  out  8  count of updates overwritten while pending; saturates at 8'hFF

Behaviour:
- Reset (async, sys_rst=1): state IDLE; all outputs 0; snapshot, shadow registers, pending flag and byte index cleared.
- Byte order (index 0..SYNC_BYTES+5):
  - SYNC_BYTES copies of SYNC_VALUE.
  - top x[11:4]; top y[7:0]; {top x[3:0], top y[11:8]}.
  - bottom x[11:4]; bottom y[7:0]; {bottom x[3:0], bottom y[11:8]}.
- Snapshot capture:
  - coord_valid in IDLE with enable=1: load snapshot from the inputs; go to LOAD on the next cycle.
  - coord_valid while packet_active, or in IDLE with enable=0: load shadow registers and set pending.
  - If pending is already set, overwrite the shadow and increment dropped_updates.
- The snapshot never changes mid-packet.
- State machine:
  - IDLE:
    - pending && enable: copy shadow to snapshot, clear pending, go to LOAD.
    - else FREE_RUN && enable: go to LOAD with the existing snapshot.
    - else coord_valid && enable: capture as above.
  - LOAD: drive tx_data for the current index; tx_start=1 for exactly this cycle; clear the timeout counter; go to WAIT_ACK. packet_active goes high in this cycle at index 0.
  - WAIT_ACK:
    - tx_busy=1: go to WAIT_DONE.
    - Timeout counter reaches ACK_TIMEOUT-1 with tx_busy=0: go to LOAD at the same index (re-issue).
  - WAIT_DONE, on tx_busy=0:
    - Index < last: increment index, go to LOAD.
    - Index = last: increment packets_sent; clear index and packet_active. Then go to LOAD (shadow copied) if pending && enable, else IDLE.
- Latency: coord_valid in IDLE to first tx_start is 2 cycles. Consecutive bytes are separated by exactly 1 idle cycle after tx_busy falls (WAIT_DONE to LOAD).
- enable falling mid-packet: the current packet completes. No new packet starts until enable=1; pending is retained.
- coord_valid in the same cycle as last-byte completion: the new data goes to the shadow (pending), and the next packet uses it.
- tx_busy already high in LOAD: WAIT_ACK sees it the next cycle; no special case.
- Reset mid-packet: immediate abort, tx_start=0, no partial count.

Test Plan:
- Basic packet: top=(12'hABC,12'h123), bottom=(12'h456,12'h789), coord_valid pulse, transmitter model with 10-cycle busy.
  - Required tx_data sequence: FF,FF,FF,AB,23,C1,45,89,67.
  - Exactly 9 tx_start pulses; packets_sent=1; packet_active low afterwards.
- Pending update: coord_valid with (12'h111,12'h222,12'h333,12'h444) during byte 4 of a packet.
  - The first packet is unchanged.
  - The second packet follows immediately: FF,FF,FF,11,22,12,33,44,34.
  - packets_sent=2; dropped_updates=0.
- Overwrite: three coord_valid pulses during one packet.
  - dropped_updates=2; the next packet carries the third set only.
- Ack timeout: transmitter ignores the first tx_start.
  - tx_start re-pulses 16 cycles later with the same tx_data.
  - The packet then completes normally with 9 bytes total delivered.
- Enable gating: enable deasserted at byte 2 with a pending update.
  - The current packet finishes; no tx_start while enable=0.
  - When enable is re-asserted, the pending packet starts 1 cycle later.
- Reset mid-packet: sys_rst asserted at byte 5.
  - Outputs go to 0 immediately, without waiting for a clock edge; packets_sent=0.
  - After release, a new coord_valid yields a full 9-byte packet starting at FF.
